// File: rtl/uart_pkg.sv
// Shared UART constants: FSM state encoding and oversampling tick positions.
// Used by both the receiver and the transmitter.
package uart_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    localparam int OVERSAMPLE = 16;
    localparam int MID_TICK   = 7;
    localparam int LAST_TICK  = 15;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous rx line, plus a previous-sample
// flop for falling-edge detection.
module uart_rx_sync (
    input  logic clk_100MHz,
    input  logic reset,
    input  logic rx,
    output logic rx_s,
    output logic fall_edge
);

    logic       rx_meta_q, rx_meta_d;
    logic       rx_s_q, rx_s_d;
    logic       rx_prev_q, rx_prev_d;
    logic [1:0] primed_q, primed_d;
    logic       armed_q, armed_d;

    // The sync flops reset high, so an edge only counts once the line has
    // really been seen high after reset; a line held low never starts a frame.
    always_comb begin
        rx_meta_d = rx;
        rx_s_d    = rx_meta_q;
        rx_prev_d = rx_s_q;
        primed_d  = {primed_q[0], 1'b1};
        armed_d   = armed_q | (primed_q[1] & rx_s_q);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
            primed_q  <= 2'b00;
            armed_q   <= 1'b0;
        end else begin
            rx_meta_q <= rx_meta_d;
            rx_s_q    <= rx_s_d;
            rx_prev_q <= rx_prev_d;
            primed_q  <= primed_d;
            armed_q   <= armed_d;
        end
    end

    assign rx_s      = rx_s_q;
    assign fall_edge = armed_q & rx_prev_q & ~rx_s_q;

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: 16x-oversampled start/data/parity/stop FSM delivering each
// word with a one-clock rx_done strobe and frame/parity error flags.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int DBITS      = 8,
    parameter int SB_TICK    = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic             clk_100MHz,
    input  logic             reset,
    input  logic             rx,
    input  logic             sample_tick,
    output logic [DBITS-1:0] data_out,
    output logic             rx_done,
    output logic             frame_err,
    output logic             parity_err
);

    localparam int TW = (SB_TICK > OVERSAMPLE) ? 5 : 4;

    logic             rx_s;
    logic             fall_edge;
    logic [2:0]       state_q, state_d;
    logic [TW-1:0]    tick_q, tick_d;
    logic [2:0]       bit_q, bit_d;
    logic [DBITS-1:0] shreg_q, shreg_d;
    logic             par_bit_q, par_bit_d;
    logic [DBITS-1:0] data_out_q, data_out_d;
    logic             rx_done_q, rx_done_d;
    logic             frame_err_q, frame_err_d;
    logic             parity_err_q, parity_err_d;

    uart_rx_sync u_sync (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .rx         (rx),
        .rx_s       (rx_s),
        .fall_edge  (fall_edge)
    );

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d      = state_q;
        tick_d       = tick_q;
        bit_d        = bit_q;
        shreg_d      = shreg_q;
        par_bit_d    = par_bit_q;
        data_out_d   = data_out_q;
        rx_done_d    = 1'b0;
        frame_err_d  = frame_err_q;
        parity_err_d = parity_err_q;

        case (state_q)
            ST_IDLE: begin
                if (fall_edge) begin
                    state_d = ST_START;
                    tick_d  = '0;
                end
            end
            ST_START: begin
                if (sample_tick) begin
                    if (tick_q == TW'(MID_TICK)) begin
                        tick_d  = '0;
                        bit_d   = '0;
                        state_d = rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            ST_DATA: begin
                if (sample_tick) begin
                    if (tick_q == TW'(LAST_TICK)) begin
                        shreg_d = {rx_s, shreg_q[DBITS-1:1]};
                        tick_d  = '0;
                        if (bit_q == 3'(DBITS - 1)) begin
                            state_d = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (sample_tick) begin
                    if (tick_q == TW'(LAST_TICK)) begin
                        par_bit_d = rx_s;
                        tick_d    = '0;
                        state_d   = ST_STOP;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            ST_STOP: begin
                if (sample_tick) begin
                    if (tick_q == TW'(SB_TICK - 1)) begin
                        state_d      = ST_IDLE;
                        rx_done_d    = 1'b1;
                        data_out_d   = shreg_q;
                        frame_err_d  = ~rx_s;
                        parity_err_d = (PARITY_EN != 0) &&
                                       ((^shreg_q ^ par_bit_q) != 1'(PARITY_ODD));
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            tick_q       <= '0;
            bit_q        <= '0;
            shreg_q      <= '0;
            par_bit_q    <= 1'b0;
            data_out_q   <= '0;
            rx_done_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_q       <= tick_d;
            bit_q        <= bit_d;
            shreg_q      <= shreg_d;
            par_bit_q    <= par_bit_d;
            data_out_q   <= data_out_d;
            rx_done_q    <= rx_done_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
        end
    end

    assign data_out   = data_out_q;
    assign rx_done    = rx_done_q;
    assign frame_err  = frame_err_q;
    assign parity_err = parity_err_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: an 8N1 instance and an 8E1 instance
// sharing the clock and a 1-in-4 sample_tick.
module tb_uart_receiver;
    import uart_pkg::*;

    localparam int BIT_CLKS = 64;

    logic       clk_100MHz;
    logic       reset;
    logic       sample_tick;
    logic       rx, rx_p;
    logic [7:0] data_out, data_out_p;
    logic       rx_done, rx_done_p;
    logic       frame_err, frame_err_p;
    logic       parity_err, parity_err_p;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int done_cnt_p = 0;
    int mark;

    uart_receiver dut (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .rx         (rx),
        .sample_tick(sample_tick),
        .data_out   (data_out),
        .rx_done    (rx_done),
        .frame_err  (frame_err),
        .parity_err (parity_err)
    );

    uart_receiver #(.PARITY_EN(1), .PARITY_ODD(0)) dut_p (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .rx         (rx_p),
        .sample_tick(sample_tick),
        .data_out   (data_out_p),
        .rx_done    (rx_done_p),
        .frame_err  (frame_err_p),
        .parity_err (parity_err_p)
    );

    initial begin
        clk_100MHz = 1'b0;
        forever #5 clk_100MHz = ~clk_100MHz;
    end

    initial begin
        sample_tick = 1'b0;
        forever begin
            repeat (3) @(negedge clk_100MHz);
            sample_tick = 1'b1;
            @(negedge clk_100MHz);
            sample_tick = 1'b0;
        end
    end

    always @(posedge clk_100MHz) begin
        if (rx_done)   done_cnt   <= done_cnt + 1;
        if (rx_done_p) done_cnt_p <= done_cnt_p + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk_100MHz);
    endtask

    task automatic drive_bit(input int which, input logic v);
        if (which == 0) rx = v;
        else            rx_p = v;
        wait_clks(BIT_CLKS);
    endtask

    task automatic send_frame(input int which, input logic [7:0] data, input logic par_en,
                              input logic par_bit, input logic stop_val);
        drive_bit(which, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(which, data[i]);
        if (par_en) drive_bit(which, par_bit);
        drive_bit(which, stop_val);
    endtask

    initial begin
        reset = 1'b1;
        rx    = 1'b1;
        rx_p  = 1'b1;
        wait_clks(3);
        check("reset_data_out", 32'(data_out), 32'h0);
        check("reset_rx_done", 32'(rx_done), 32'h0);
        check("reset_frame_err", 32'(frame_err), 32'h0);
        check("reset_parity_err", 32'(parity_err), 32'h0);
        check("reset_state", 32'(dut.state_q), 32'(ST_IDLE));
        reset = 1'b0;
        wait_clks(20);

        // 8N1 0xA5
        mark = done_cnt;
        send_frame(0, 8'hA5, 1'b0, 1'b0, 1'b1);
        check("a5_done_count", 32'(done_cnt - mark), 32'd1);
        check("a5_data", 32'(data_out), 32'hA5);
        check("a5_frame_err", 32'(frame_err), 32'h0);
        check("a5_parity_err", 32'(parity_err), 32'h0);
        wait_clks(100);

        // Short low glitch shorter than half a bit
        mark = done_cnt;
        rx = 1'b0;
        wait_clks(16);
        rx = 1'b1;
        wait_clks(100);
        check("glitch_no_done", 32'(done_cnt - mark), 32'd0);
        check("glitch_state_idle", 32'(dut.state_q), 32'(ST_IDLE));
        check("glitch_data_kept", 32'(data_out), 32'hA5);
        send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1);
        check("3c_done_count", 32'(done_cnt - mark), 32'd1);
        check("3c_data", 32'(data_out), 32'h3C);
        wait_clks(100);

        // Stop bit low, line held low afterwards (break)
        mark = done_cnt;
        send_frame(0, 8'h55, 1'b0, 1'b0, 1'b0);
        check("55_done_count", 32'(done_cnt - mark), 32'd1);
        check("55_data", 32'(data_out), 32'h55);
        check("55_frame_err", 32'(frame_err), 32'h1);
        wait_clks(1200);
        check("break_no_more_done", 32'(done_cnt - mark), 32'd1);
        rx = 1'b1;
        wait_clks(100);

        // 8E1: data 0x07 has odd ones, so even parity needs bit = 1
        mark = done_cnt_p;
        send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1);
        check("par_ok_done", 32'(done_cnt_p - mark), 32'd1);
        check("par_ok_data", 32'(data_out_p), 32'h07);
        check("par_ok_parity_err", 32'(parity_err_p), 32'h0);
        wait_clks(100);
        send_frame(1, 8'h07, 1'b1, 1'b0, 1'b1);
        check("par_bad_done", 32'(done_cnt_p - mark), 32'd2);
        check("par_bad_data", 32'(data_out_p), 32'h07);
        check("par_bad_parity_err", 32'(parity_err_p), 32'h1);
        check("par_bad_frame_err", 32'(frame_err_p), 32'h0);
        wait_clks(100);

        // Back-to-back frames with zero idle gap
        mark = done_cnt;
        send_frame(0, 8'h00, 1'b0, 1'b0, 1'b1);
        check("b2b_first_data", 32'(data_out), 32'h00);
        check("b2b_first_frame_err", 32'(frame_err), 32'h0);
        send_frame(0, 8'hFF, 1'b0, 1'b0, 1'b1);
        check("b2b_done_count", 32'(done_cnt - mark), 32'd2);
        check("b2b_second_data", 32'(data_out), 32'hFF);
        check("b2b_frame_err", 32'(frame_err), 32'h0);
        wait_clks(100);

        // Reset in the middle of data bit 3 of 0x96 (bit 3 is 0)
        mark = done_cnt;
        drive_bit(0, 1'b0);
        drive_bit(0, 1'b0);
        drive_bit(0, 1'b1);
        drive_bit(0, 1'b1);
        rx = 1'b0;
        wait_clks(32);
        reset = 1'b1;
        #1;
        check("midreset_data_out", 32'(data_out), 32'h0);
        check("midreset_rx_done", 32'(rx_done), 32'h0);
        check("midreset_frame_err", 32'(frame_err), 32'h0);
        check("midreset_state", 32'(dut.state_q), 32'(ST_IDLE));
        wait_clks(4);
        reset = 1'b0;
        wait_clks(1200);
        check("low_after_reset_no_done", 32'(done_cnt - mark), 32'd0);
        check("low_after_reset_idle", 32'(dut.state_q), 32'(ST_IDLE));
        rx = 1'b1;
        wait_clks(BIT_CLKS);
        send_frame(0, 8'h96, 1'b0, 1'b0, 1'b1);
        check("96_done_count", 32'(done_cnt - mark), 32'd1);
        check("96_data", 32'(data_out), 32'h96);
        check("96_frame_err", 32'(frame_err), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
Serial-to-parallel UART receiver: the receive end of the link driven by the team's UART transmitter.
- Samples the asynchronous rx line using the shared 16x-oversampling sample_tick from the baud rate generator.
- Validates the start bit, assembles DBITS data bits LSB-first, optionally checks parity, then checks the stop bit.
- Presents the received word with a one-clock done strobe and error flags to the downstream FIFO/consumer.

Parameters:
DBITS, 8, number of data bits per frame (5..8)
SB_TICK, 16, sample ticks per stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2)
PARITY_EN, 0, 1 = one parity bit follows the data bits
PARITY_ODD, 0, 1 = odd parity, 0 = even parity (ignored when PARITY_EN = 0)

Ports:
clk_100MHz  input  1  system clock, 100 MHz
reset  input  1  asynchronous, active-high reset
rx  input  1  serial receive line, asynchronous to clk_100MHz, idles high
sample_tick  input  1  one-clock pulse at 16x baud, from baud rate generator
data_out  output  DBITS  last received word, registered
rx_done  output  1  one-clock pulse: data_out and flags updated this cycle
frame_err  output  1  stop bit sampled low on last frame
parity_err  output  1  parity mismatch on last frame (always 0 when PARITY_EN = 0)

Behaviour:
- Interface: reset is asynchronous and active-high; clock is clk_100MHz.
- Reset values: data_out = 0, rx_done = 0, frame_err = 0, parity_err = 0, state = idle, tick counter = 0, bit counter = 0, synchronizer and previous-sample flops = 1.
- rx passes through a 2-flop synchronizer; rx_s denotes its output. rx_prev is rx_s delayed one clock.
- States: idle, start, data, parity, stop. The 4-bit tick counter advances only on clocks where sample_tick = 1.
- idle: on a falling edge (rx_prev = 1, rx_s = 0), go to start and clear the tick counter. A line held low (break) never starts a frame.
- start: on the sample_tick where tick = 7 (mid-bit):
  - rx_s = 0: go to data, clear tick and bit counters.
  - rx_s = 1: treat as a glitch, return to idle; no rx_done, outputs unchanged.
- data: on the sample_tick where tick = 15, shift right: shreg = {rx_s, shreg[DBITS-1:1]}, clear tick.
  - After bit DBITS-1, go to parity if PARITY_EN = 1, else go to stop.
  - The first bit received ends at shreg[0].
- parity: on tick = 15, capture rx_s as the parity bit, clear tick, go to stop.
  - Error condition: XOR(shreg, parity bit) != PARITY_ODD.
- stop: on tick = SB_TICK-1, sample rx_s and go to idle. On the next clk_100MHz edge:
  - rx_done = 1 for exactly one clock.
  - data_out = shreg.
  - frame_err = ~rx_s.
  - parity_err = computed mismatch, or 0 when parity is disabled.
- data_out, frame_err and parity_err hold until the next rx_done.
- The tick counter needs SB_TICK-1 to fit in its width. Widen it to 5 bits when SB_TICK > 16.
- Sampling latency: every bit is sampled 8 ticks after its nominal edge, i.e. mid-bit.
- Frame end latency: rx_done follows the stop-bit mid-point at SB_TICK-1 ticks after the last data/parity sample.
- A frame with an error still asserts rx_done; the data is delivered with its flags.
- Back-to-back frames: a start edge is accepted on the first idle clock after stop, so a zero-gap next frame is received.
- Reset mid-frame: everything returns to reset values immediately and no rx_done is produced. A new frame is accepted only after rx is seen high and then falls.
- sample_tick during idle has no effect.

Decomposition:
- Shared package uart_pkg:
  - state encoding localparams (idle/start/data/parity/stop, 3-bit);
  - OVERSAMPLE = 16;
  - MID_TICK = 7;
  - LAST_TICK = 15.
- The transmitter uses the same package.
- One natural sub-module: uart_rx_sync.
  - 2-flop synchronizer plus previous-sample flop.
  - Outputs rx_s and fall_edge.
  - Reset value 1.

Test Plan:
- 8N1, sample_tick every 4 clocks, send 0xA5 → one rx_done pulse after the stop mid-bit, data_out = 0xA5, frame_err = 0, parity_err = 0.
- rx low for 4 ticks then high (glitch) → no rx_done, FSM back in idle; a following 0x3C frame → data_out = 0x3C.
- Send 0x55 with stop bit driven low and rx held low afterwards → rx_done, data_out = 0x55, frame_err = 1. No further rx_done until rx goes high and falls again.
- PARITY_EN = 1, PARITY_ODD = 0, data 0x07:
  - parity bit 1 → parity_err = 0;
  - parity bit 0 → parity_err = 1, data_out = 0x07.
- Back-to-back 0x00 then 0xFF with zero idle gap → two rx_done pulses, data_out = 0x00 then 0xFF, no errors.
- Assert reset during data bit 3 of 0x96 → all outputs 0, no rx_done. A subsequent 0x96 frame → data_out = 0x96.
